// File: rtl/timer_dev_pkg.sv
// timer_dev_pkg: shared state encoding, register map, CTRL layout and MODE codes for timer_dev
package timer_dev_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 3;
    localparam logic [1:0] MODE_AUTO = 2'b01;
endpackage

// File: rtl/timer_dev.sv
// timer_dev: bus-programmed down-counting timer with one-shot/auto-reload modes and masked interrupt
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter int CNT_WD = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);
    state_e              state_q, state_d;
    logic [CNT_WD-1:0]   preset_q, count_q, count_d;
    logic [1:0]          mode_q;
    logic                en_q, im_q, pend_q;
    logic                wr_ctrl, wr_preset, stop, pend_set, hw_clr;

    assign wr_ctrl   = sel & we & (addr == OFF_CTRL);
    assign wr_preset = sel & we & (addr == OFF_PRESET);
    assign stop      = wr_ctrl & ~din[CTRL_EN];
    assign irq       = pend_q & im_q;
    assign dout      = !sel                 ? 32'd0 :
                       addr == OFF_CTRL     ? {28'd0, im_q, mode_q, en_q} :
                       addr == OFF_PRESET   ? 32'(preset_q) :
                       addr == OFF_COUNT    ? 32'(count_q) : 32'd0;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // next state and counter update; a disabling CTRL write aborts immediately and freezes COUNT
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        pend_set = 1'b0;
        hw_clr   = 1'b0;
        case (state_q)
            ST_IDLE: state_d = en_q ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en_q) state_d = ST_IDLE;
                else if (count_q > CNT_WD'(1)) count_d = count_q - CNT_WD'(1);
                else begin
                    count_d  = '0;
                    pend_set = 1'b1;
                    state_d  = ST_INT;
                end
            end
            ST_INT: begin
                hw_clr  = (mode_q != MODE_AUTO);
                state_d = (mode_q == MODE_AUTO) ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (stop) begin
            state_d = ST_IDLE;
            count_d = count_q;
        end
    end

    // programmer-visible registers; software EN write beats hardware clear, pend set beats CTRL clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pend_q  <= pend_set | (pend_q & ~wr_ctrl);
            if (wr_ctrl) begin
                en_q   <= din[CTRL_EN];
                mode_q <= din[CTRL_MODE +: 2];
                im_q   <= din[CTRL_IM];
            end else if (hw_clr) en_q <= 1'b0;
            if (wr_preset) preset_q <= din[CNT_WD-1:0];
        end
    end
endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed self-checking bench for timer_dev
module tb_timer_dev;
    localparam logic [1:0] A_CTRL = 2'd0, A_PRE = 2'd1, A_CNT = 2'd2, A_RSV = 2'd3;
    logic        clk = 1'b0, rst = 1'b0, sel = 1'b0, we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] din = 32'd0;
    logic [31:0] dout;
    logic        irq;
    int checks = 0, errors = 0;

    timer_dev #(.CNT_WD(32)) dut (
        .clk(clk), .rst(rst), .sel(sel), .addr(addr), .we(we),
        .din(din), .dout(dout), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; din = d;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        chk(tag, dout, exp);
        sel = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_cnt [1:7];
        exp_cnt = '{32'd0, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        #1;
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rd("rst_ctrl", A_CTRL, 32'd0);
        rd("rst_count", A_CNT, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        // one-shot with interrupt enabled
        wr(A_PRE, 32'd5);
        rd("preset5", A_PRE, 32'd5);
        wr(A_CNT, 32'd55);
        rd("count_wr_ignored", A_CNT, 32'd0);
        wr(A_RSV, 32'hFFFF_FFFF);
        rd("rsvd_reads0", A_RSV, 32'd0);
        addr = A_PRE;
        #1;
        chk("nosel_dout0", dout, 32'd0);
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 7; k++) begin
            step();
            rd($sformatf("oneshot_cnt%0d", k), A_CNT, exp_cnt[k]);
            if (k == 6) chk("oneshot_irq_early", {31'd0, irq}, 32'd0);
        end
        chk("oneshot_irq_t7", {31'd0, irq}, 32'd1);
        step();
        rd("oneshot_en_cleared", A_CTRL, 32'h8);
        chk("oneshot_irq_held", {31'd0, irq}, 32'd1);
        // masked interrupt
        wr(A_CTRL, 32'h0);
        chk("ctrl_wr_clears_irq", {31'd0, irq}, 32'd0);
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'h1);
        step(4);
        rd("masked_cnt0", A_CNT, 32'd0);
        chk("masked_irq0", {31'd0, irq}, 32'd0);
        step();
        rd("masked_ctrl", A_CTRL, 32'h0);
        wr(A_CTRL, 32'h8);
        chk("im_on_pend_cleared", {31'd0, irq}, 32'd0);
        // auto-reload
        wr(A_PRE, 32'd3);
        wr(A_CTRL, 32'hB);
        step(2);
        rd("auto_cnt_t2", A_CNT, 32'd3);
        step(2);
        rd("auto_cnt_t4", A_CNT, 32'd1);
        chk("auto_irq_t4", {31'd0, irq}, 32'd0);
        step();
        rd("auto_cnt_t5", A_CNT, 32'd0);
        chk("auto_irq_t5", {31'd0, irq}, 32'd1);
        step();
        rd("auto_cnt_t6", A_CNT, 32'd0);
        wr(A_CTRL, 32'hB);
        rd("auto_reload_t7", A_CNT, 32'd3);
        chk("auto_irq_t7", {31'd0, irq}, 32'd0);
        step(2);
        chk("auto_irq_t9", {31'd0, irq}, 32'd0);
        step();
        chk("auto_irq_t10", {31'd0, irq}, 32'd1);
        rd("auto_ctrl", A_CTRL, 32'hB);
        // mid-count stop and restart
        wr(A_CTRL, 32'h0);
        chk("stop_clears_irq", {31'd0, irq}, 32'd0);
        wr(A_PRE, 32'd9);
        wr(A_CTRL, 32'h1);
        step(2);
        rd("stop_cnt_t2", A_CNT, 32'd9);
        step(2);
        rd("stop_cnt_t4", A_CNT, 32'd7);
        wr(A_CTRL, 32'h0);
        rd("stop_hold_now", A_CNT, 32'd7);
        step(3);
        rd("stop_hold_later", A_CNT, 32'd7);
        chk("stop_irq0", {31'd0, irq}, 32'd0);
        wr(A_CTRL, 32'h1);
        step();
        rd("restart_load_pending", A_CNT, 32'd7);
        step();
        rd("restart_reloaded", A_CNT, 32'd9);
        // PRESET=0 and CTRL write on pend-set edge
        wr(A_CTRL, 32'h0);
        wr(A_PRE, 32'd0);
        wr(A_CTRL, 32'h9);
        step(2);
        rd("p0_cnt", A_CNT, 32'd0);
        chk("p0_irq_before", {31'd0, irq}, 32'd0);
        wr(A_CTRL, 32'h9);
        chk("pend_set_wins", {31'd0, irq}, 32'd1);
        step();
        rd("p0_en_cleared", A_CTRL, 32'h8);
        // software EN write on the hardware-clear edge
        wr(A_CTRL, 32'h9);
        step(3);
        chk("sw_race_irq_pre", {31'd0, irq}, 32'd1);
        wr(A_CTRL, 32'h9);
        rd("sw_en_wins", A_CTRL, 32'h9);
        chk("sw_race_irq_clr", {31'd0, irq}, 32'd0);
        step(3);
        chk("sw_race_rerun_irq", {31'd0, irq}, 32'd1);
        // asynchronous reset mid-count
        wr(A_CTRL, 32'h0);
        wr(A_PRE, 32'd100);
        wr(A_CTRL, 32'h9);
        step(2);
        rd("pre_rst_cnt", A_CNT, 32'd100);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_irq", {31'd0, irq}, 32'd0);
        rd("rst_async_cnt", A_CNT, 32'd0);
        rd("rst_async_ctrl", A_CTRL, 32'd0);
        rd("rst_async_pre", A_PRE, 32'd0);
        #1;
        rst = 1'b1;
        step(110);
        chk("post_rst_irq", {31'd0, irq}, 32'd0);
        rd("post_rst_cnt", A_CNT, 32'd0);
        wr(A_PRE, 32'd4);
        rd("post_rst_write", A_PRE, 32'd4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
